// File: rtl/binary_encoder_pkg.sv
// Shared constants and helpers for the binary_encoder slice.
//   BENC_IN_W_DEF   : default binary input width
//   benc_out_w()    : one-hot output width for a given input width (2**in_w)
//   benc_is_onehot0 : true when at most one bit of vec is set
package binary_encoder_pkg;

  localparam int BENC_IN_W_DEF = 2;

  function automatic int benc_out_w(input int in_w);
    return 1 << in_w;
  endfunction

  // Clearing the lowest set bit leaves zero only for one-hot or all-zero input.
  // 64 bits covers the largest legal output (IN_W=6).
  function automatic logic benc_is_onehot0(input logic [63:0] vec);
    return (vec & (vec - 64'd1)) == 64'd0;
  endfunction

endpackage

// File: rtl/binary_encoder_if.sv
// Decode request/result bundle for binary_encoder.
//   en, val          : decode enable and binary code (driven by master)
//   bcode, bcode_vld : registered one-hot result and its valid (driven by slave)
//   bcode_err        : sticky one-hot checker flag, only with BINARY_ENCODER_ONEHOT_CHK_EN
// IN_W must match the IN_W of the binary_encoder it is bound to.
interface binary_encoder_if
  import binary_encoder_pkg::*;
#(
  parameter int IN_W = BENC_IN_W_DEF,
  localparam int OUT_W = benc_out_w(IN_W)
);
  logic             en;
  logic [IN_W-1:0]  val;
  logic [OUT_W-1:0] bcode;
  logic             bcode_vld;
`ifdef BINARY_ENCODER_ONEHOT_CHK_EN
  logic             bcode_err;

  modport master (output en, val, input bcode, bcode_vld, bcode_err);
  modport slave  (input en, val, output bcode, bcode_vld, bcode_err);
`else
  modport master (output en, val, input bcode, bcode_vld);
  modport slave  (input en, val, output bcode, bcode_vld);
`endif
endinterface

// File: rtl/binary_encoder_dec.sv
// Combinational IN_W -> 2**IN_W one-hot decode with enable gating.
//   en  : low forces dec to zero (val is ignored, even if X)
//   val : binary code
//   dec : one-hot (en=1) or zero (en=0)
module binary_encoder_dec
  import binary_encoder_pkg::*;
#(
  parameter int IN_W = BENC_IN_W_DEF,
  localparam int OUT_W = benc_out_w(IN_W)
) (
  input  logic             en,
  input  logic [IN_W-1:0]  val,
  output logic [OUT_W-1:0] dec
);
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign dec[i] = en && (val == IN_W'(i));
  end
endmodule

// File: rtl/binary_encoder.sv
// Registered N-to-2**N one-hot decoder with enable.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears bcode, bcode_vld, bcode_err)
//   bus : binary_encoder_if.slave -- en/val in, bcode/bcode_vld out
// Outputs update one clk after en/val are sampled; no combinational path.
// Optional macro BINARY_ENCODER_ONEHOT_CHK_EN adds bus.bcode_err, a sticky flag
// raised one cycle after the output register is seen not one-hot-or-zero or
// disagreeing with bcode_vld (upset/corruption detection).
module binary_encoder
  import binary_encoder_pkg::*;
#(
  parameter int IN_W = BENC_IN_W_DEF,
  localparam int OUT_W = benc_out_w(IN_W)
) (
  input  logic clk,
  input  logic rst,
  binary_encoder_if.slave bus
);
  logic [OUT_W-1:0] dec;
  logic [OUT_W-1:0] bcode_q;
  logic             vld_q;

  binary_encoder_dec #(.IN_W(IN_W)) u_dec (
    .en  (bus.en),
    .val (bus.val),
    .dec (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcode_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      bcode_q <= dec;
      vld_q   <= bus.en;
    end
  end

  assign bus.bcode     = bcode_q;
  assign bus.bcode_vld = vld_q;

`ifdef BINARY_ENCODER_ONEHOT_CHK_EN
  logic err_q;

  // Checks the register contents, not dec, so upsets in the flops are caught.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (!benc_is_onehot0(64'(bcode_q)) || (vld_q != (|bcode_q))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.bcode_err = err_q;
`endif
endmodule

// File: tb/tb_binary_encoder.sv
module tb_binary_encoder;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  binary_encoder_if #(.IN_W(2)) bus ();
  binary_encoder #(.IN_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] val;
    logic [3:0] exp_bcode;
    logic       exp_vld;
  } vec_t;

  vec_t tbl[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eb, input logic ev);
    checks++;
    if (bus.bcode !== eb || bus.bcode_vld !== ev) begin
      failures++;
      $display("FAIL %s: bcode=%b vld=%b expected bcode=%b vld=%b",
               name, bus.bcode, bus.bcode_vld, eb, ev);
    end
`ifdef BINARY_ENCODER_ONEHOT_CHK_EN
    checks++;
    if (bus.bcode_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_err: bcode_err=%b expected 0", name, bus.bcode_err);
    end
`endif
  endtask

  initial begin
    // expected values are those seen one edge after the row's inputs are sampled
    tbl = '{
      '{1'b0, 2'b00, 4'b0000, 1'b0},  // disabled
      '{1'b0, 2'b11, 4'b0000, 1'b0},  // disabled, val ignored
      '{1'b1, 2'b00, 4'b0001, 1'b1},  // full decode, back to back
      '{1'b1, 2'b01, 4'b0010, 1'b1},
      '{1'b1, 2'b10, 4'b0100, 1'b1},
      '{1'b1, 2'b11, 4'b1000, 1'b1},
      '{1'b1, 2'b10, 4'b0100, 1'b1},  // enable toggle 1 -> 0 -> 1
      '{1'b0, 2'b10, 4'b0000, 1'b0},
      '{1'b1, 2'b01, 4'b0010, 1'b1},
      '{1'b0, 2'bxx, 4'b0000, 1'b0},  // X val while disabled
      '{1'b1, 2'b11, 4'b1000, 1'b1},  // 0 -> 1 re-enable
      '{1'b1, 2'b00, 4'b0001, 1'b1}   // wrap 11 -> 00 without bubble
    };

    // reset held with en=1, val=11: outputs stay zero across edges
    rst = 1'b1;
    bus.en = 1'b1;
    bus.val = 2'b11;
    #2;
    check("reset_async", 4'b0000, 1'b0);
    step();
    step();
    check("reset_held", 4'b0000, 1'b0);
    rst = 1'b0;
    step();
    check("release_first", 4'b1000, 1'b1);

    for (int i = 0; i < 12; i++) begin
      bus.en = tbl[i].en;
      bus.val = tbl[i].val;
      step();
      check($sformatf("vec%0d", i), tbl[i].exp_bcode, tbl[i].exp_vld);
      checks++;
      if (bus.bcode_vld !== (|bus.bcode)) begin
        failures++;
        $display("FAIL vld_inv%0d: bcode_vld=%b bcode=%b", i, bus.bcode_vld, bus.bcode);
      end
    end

    // mid-stream reset between edges
    bus.en = 1'b1;
    bus.val = 2'b11;
    step();
    check("mid_pre", 4'b1000, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async", 4'b0000, 1'b0);
    step();
    check("mid_held", 4'b0000, 1'b0);
    rst = 1'b0;
    bus.en = 1'b0;
    step();
    check("mid_rel_en0", 4'b0000, 1'b0);
    bus.en = 1'b1;
    bus.val = 2'b10;
    step();
    check("mid_rel_en1", 4'b0100, 1'b1);

`ifdef BINARY_ENCODER_ONEHOT_CHK_EN
    // corrupt the output register: two bits set
    #2;
    force dut.bcode_q = 4'b0110;
    step();
    release dut.bcode_q;
    checks++;
    if (bus.bcode_err !== 1'b1) begin
      failures++;
      $display("FAIL err_rise: bcode_err=%b expected 1", bus.bcode_err);
    end
    bus.en = 1'b1;
    bus.val = 2'b01;
    step();
    step();
    checks++;
    if (bus.bcode_err !== 1'b1 || bus.bcode !== 4'b0010) begin
      failures++;
      $display("FAIL err_sticky: bcode_err=%b bcode=%b expected 1 0010", bus.bcode_err, bus.bcode);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.bcode_err !== 1'b0) begin
      failures++;
      $display("FAIL err_reset: bcode_err=%b expected 0", bus.bcode_err);
    end
    rst = 1'b0;
    step();
    step();
    check("err_after_rst", 4'b0010, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/binary_encoder.md
Name: binary_encoder

Overview:
Registered N-to-2^N one-hot decoder with enable. The binary code on val selects which single bit of bcode is driven high. When en is low, bcode is all zeros. It is used as the select/strobe generator in front of small register banks and mux trees; the default configuration is 2-bit in, 4-bit out.

Parameters:
IN_W, 2, width of binary input val; legal range 1..6
OUT_W, 2**IN_W, width of one-hot output bcode; derived, must not be overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  decode enable; low forces output to zero
val  input  IN_W  binary code to decode
bcode  output  OUT_W  registered one-hot (or all-zero) decode result
bcode_vld  output  1  registered copy of en; high when bcode holds a decoded code

Behaviour:
- Reset: rst is asynchronous and active-high. While rst=1, bcode=0 and bcode_vld=0, immediately and independent of clk. Release is synchronous to the next clk rising edge.
- Decode function, next-state:
  - en=1: bcode_next[i] = (i == val) for i in 0..OUT_W-1. Exactly one bit is set.
  - en=0: bcode_next = 0, regardless of val.
- Mapping for IN_W=2:
  - val 00 -> 0001
  - val 01 -> 0010
  - val 10 -> 0100
  - val 11 -> 1000
- Latency: bcode and bcode_vld update 1 clk after en/val are sampled. There is no combinational path from inputs to outputs.
- bcode_vld = en registered. The invariant is bcode_vld == |bcode at all times outside reset.
- Every val value is in range (OUT_W = 2^IN_W), so there is no out-of-range case.
- X on val while en=1 is a bench error. X on val while en=0 must still yield bcode=0.
- Input changes every cycle are supported: back-to-back codes produce back-to-back one-hot outputs with no bubble.
- Toggling en from 1 to 0 clears bcode on the next edge. Toggling en from 0 to 1 presents the decoded val on the next edge.
- rst asserted mid-stream clears outputs at once. The first decode after release appears one edge after the first sampled en=1.

Optional Feature:
Macro BINARY_ENCODER_ONEHOT_CHK_EN.
- Defined: adds output port bcode_err (1 bit, registered, reset 0).
  - Each cycle, bcode is checked for being one-hot-or-zero and for consistency with bcode_vld.
  - On violation (more than one bit set, or bcode_vld != |bcode), bcode_err rises one cycle later.
  - bcode_err is sticky until rst.
  - This catches upsets or corruption of the output register.
- Undefined: no bcode_err port and no checker logic. Port list is exactly as above.

Decomposition:
- Package binary_encoder_pkg holds:
  - localparam BENC_IN_W_DEF = 2
  - function benc_out_w(in_w) returning 2**in_w
  - function benc_is_onehot0(vec), used by the optional checker
- Sub-module binary_encoder_dec: purely combinational IN_W -> OUT_W decode with en gating, no clock. binary_encoder instantiates it and adds the output register, vld register and optional checker.

Test Plan:
- Reset: rst=1 with en=1, val=11 -> bcode=0000, bcode_vld=0 asynchronously. After release, the next edge gives 1000 with vld=1.
- Disabled: en=0, val=00, then en=0, val=11 -> bcode=0000, bcode_vld=0 on each following edge.
- Full decode: en=1, val=00/01/10/11 on consecutive cycles -> bcode=0001/0010/0100/1000 one cycle later each, vld=1 throughout, no bubbles.
- Enable toggle: en=1 val=10 then en=0 val=10 then en=1 val=01 -> bcode 0100, 0000, 0010. vld follows 1, 0, 1.
- Mid-stream reset: assert rst asynchronously between edges while bcode=1000 -> bcode drops to 0000 before the next edge and stays 0000 until the edge after release with en=1.
- With BINARY_ENCODER_ONEHOT_CHK_EN: force the output register to 0110 -> bcode_err=1 next cycle and stays 1 until rst. In normal operation over all codes, bcode_err stays 0.
